// File: rtl/ej32_pkg.sv
// Shared eJ32 types: stack op encoding, data unit type and stack depths.
package ej32_pkg;
  typedef enum logic [1:0] {
    sNOP  = 2'd0,
    sPUSH = 2'd1,
    sMOVE = 2'd2,
    sPOP  = 2'd3
  } stack_op;

  typedef logic [31:0] DU;

  localparam int DSTACK_DEPTH = 64;
  localparam int RSTACK_DEPTH = 32;
endpackage

// File: rtl/ej32_stack_if.sv
// Stack control/status bundle. Pick port appears only with EJ32_STACK_PICK_EN.
interface ej32_stack_if import ej32_pkg::*; #(
  parameter int DW    = 32,
  parameter int DEPTH = 64
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  stack_op       op;
  logic [DW-1:0] din;
  logic          clr_flags;
  logic [DW-1:0] tos;
  logic [DW-1:0] nos;
  logic [CW-1:0] cnt;
  logic          full;
  logic          empty;
  logic          ovf;
  logic          unf;
`ifdef EJ32_STACK_PICK_EN
  logic [CW-2:0] pick_idx;
  logic [DW-1:0] pick_data;
  logic          pick_oor;

  modport master (output op, din, clr_flags, pick_idx,
                  input  tos, nos, cnt, full, empty, ovf, unf, pick_data, pick_oor);
  modport slave  (input  op, din, clr_flags, pick_idx,
                  output tos, nos, cnt, full, empty, ovf, unf, pick_data, pick_oor);
`else
  modport master (output op, din, clr_flags,
                  input  tos, nos, cnt, full, empty, ovf, unf);
  modport slave  (input  op, din, clr_flags,
                  output tos, nos, cnt, full, empty, ovf, unf);
`endif
endinterface

// File: rtl/ej32_stack_rf.sv
// Below-TOS storage: DEPTH-1 entries, one sync write, one async read
// (plus a second async read for picks under EJ32_STACK_PICK_EN).
module ej32_stack_rf #(
  parameter int DW    = 32,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
`ifdef EJ32_STACK_PICK_EN
  ,
  input  logic [AW-1:0] praddr,
  output logic [DW-1:0] prdata
`endif
);
  logic [DW-1:0] mem [DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The top address has no entry; callers gate it, this just keeps it defined.
  assign rdata = (raddr < AW'(DEPTH - 1)) ? mem[raddr] : '0;
`ifdef EJ32_STACK_PICK_EN
  assign prdata = (praddr < AW'(DEPTH - 1)) ? mem[praddr] : '0;
`endif
endmodule

// File: rtl/ej32_stack.sv
// Parametrised eJ32 data/return stack: registered TOS over a register file,
// occupancy count and sticky ovf/unf. EJ32_STACK_PICK_EN adds a pick read port.
module ej32_stack import ej32_pkg::*; #(
  parameter int DW    = 32,
  parameter int DEPTH = 64
) (
  input logic        clk,
  input logic        rst,
  ej32_stack_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = CW - 1;

  logic [DW-1:0] tos_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q, unf_q;
  logic          is_push, is_pop, is_move;
  logic          at_full, at_empty, has_nos, we;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] rdata, nos_v;

  assign is_push  = bus.op == sPUSH;
  assign is_pop   = bus.op == sPOP;
  assign is_move  = bus.op == sMOVE;
  assign at_full  = cnt_q == CW'(DEPTH);
  assign at_empty = cnt_q == '0;
  assign has_nos  = cnt_q >= CW'(2);

  // Old TOS sinks to mem[cnt-1]; NOS is read from mem[cnt-2] with pre-edge cnt.
  assign we    = is_push & ~at_full & ~at_empty;
  assign waddr = AW'(cnt_q - CW'(1));
  assign raddr = AW'(cnt_q - CW'(2));
  assign nos_v = has_nos ? rdata : '0;

`ifdef EJ32_STACK_PICK_EN
  logic [AW-1:0] paddr;
  logic [DW-1:0] prdata;

  assign paddr = AW'(cnt_q - CW'(1) - CW'(bus.pick_idx));
`endif

  ej32_stack_rf #(.DW(DW), .DEPTH(DEPTH)) u_rf (
    .clk    (clk),
    .we     (we),
    .waddr  (waddr),
    .wdata  (tos_q),
    .raddr  (raddr),
    .rdata  (rdata)
`ifdef EJ32_STACK_PICK_EN
    ,
    .praddr (paddr),
    .prdata (prdata)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tos_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      case (bus.op)
        sPUSH: if (!at_full) begin
          tos_q <= bus.din;
          cnt_q <= cnt_q + CW'(1);
        end
        sPOP: if (!at_empty) begin
          tos_q <= nos_v;
          cnt_q <= cnt_q - CW'(1);
        end
        sMOVE: tos_q <= bus.din;
        default: ;
      endcase
      // A fresh error in the clearing cycle still sets the flag.
      ovf_q <= (is_push & at_full) | (ovf_q & ~bus.clr_flags);
      unf_q <= ((is_pop | is_move) & at_empty) | (unf_q & ~bus.clr_flags);
    end
  end

  assign bus.tos   = tos_q;
  assign bus.nos   = nos_v;
  assign bus.cnt   = cnt_q;
  assign bus.full  = at_full;
  assign bus.empty = at_empty;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;

`ifdef EJ32_STACK_PICK_EN
  always_comb begin
    bus.pick_data = '0;
    bus.pick_oor  = 1'b0;
    if (bus.pick_idx == '0)
      bus.pick_data = tos_q;
    else if (CW'(bus.pick_idx) < cnt_q)
      bus.pick_data = prdata;
    else
      bus.pick_oor = 1'b1;
  end
`endif
endmodule

// File: tb/tb_ej32_stack.sv
// Drives a 64-deep and a 4-deep stack with one op stream and compares both
// against queue-based reference stacks.
module tb_ej32_stack import ej32_pkg::*;;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ej32_stack_if #(.DW(32), .DEPTH(DSTACK_DEPTH)) bd ();
  ej32_stack_if #(.DW(32), .DEPTH(4))            bs ();

  ej32_stack #(.DW(32), .DEPTH(DSTACK_DEPTH)) u_d (.clk(clk), .rst(rst), .bus(bd));
  ej32_stack #(.DW(32), .DEPTH(4))            u_s (.clk(clk), .rst(rst), .bus(bs));

  int total  = 0;
  int passes = 0;

  // Reference: whole stack as a list, top at the back.
  logic [31:0] stk [2][$];
  logic [31:0] etos [2];
  logic        movf [2];
  logic        munf [2];
  int          dep  [2] = '{DSTACK_DEPTH, 4};

  function automatic logic [31:0] m_tos(int k);
    return (stk[k].size() > 0) ? stk[k][stk[k].size()-1] : etos[k];
  endfunction

  function automatic logic [31:0] m_nos(int k);
    return (stk[k].size() >= 2) ? stk[k][stk[k].size()-2] : 32'h0;
  endfunction

  function automatic void m_apply(int k, stack_op op, logic [31:0] d, logic clr, logic r);
    int  n = stk[k].size();
    logic eo, eu;
    if (r) begin
      stk[k].delete(); etos[k] = '0; movf[k] = 1'b0; munf[k] = 1'b0;
      return;
    end
    eo = (op == sPUSH) && (n == dep[k]);
    eu = ((op == sPOP) || (op == sMOVE)) && (n == 0);
    case (op)
      sPUSH: if (n < dep[k]) stk[k].push_back(d);
      sPOP:  if (n > 0) begin
        void'(stk[k].pop_back());
        if (stk[k].size() == 0) etos[k] = '0;
      end
      sMOVE: if (n > 0) stk[k][n-1] = d; else etos[k] = d;
      default: ;
    endcase
    movf[k] = eo | (movf[k] & ~clr);
    munf[k] = eu | (munf[k] & ~clr);
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic check_all(string tag);
    chk({tag, ":d.tos"},   bd.tos,        m_tos(0));
    chk({tag, ":d.nos"},   bd.nos,        m_nos(0));
    chk({tag, ":d.cnt"},   32'(bd.cnt),   32'(stk[0].size()));
    chk({tag, ":d.full"},  32'(bd.full),  32'(stk[0].size() == dep[0]));
    chk({tag, ":d.empty"}, 32'(bd.empty), 32'(stk[0].size() == 0));
    chk({tag, ":d.ovf"},   32'(bd.ovf),   32'(movf[0]));
    chk({tag, ":d.unf"},   32'(bd.unf),   32'(munf[0]));
    chk({tag, ":s.tos"},   bs.tos,        m_tos(1));
    chk({tag, ":s.nos"},   bs.nos,        m_nos(1));
    chk({tag, ":s.cnt"},   32'(bs.cnt),   32'(stk[1].size()));
    chk({tag, ":s.full"},  32'(bs.full),  32'(stk[1].size() == dep[1]));
    chk({tag, ":s.empty"}, 32'(bs.empty), 32'(stk[1].size() == 0));
    chk({tag, ":s.ovf"},   32'(bs.ovf),   32'(movf[1]));
    chk({tag, ":s.unf"},   32'(bs.unf),   32'(munf[1]));
  endtask

  task automatic step(string tag, stack_op op, logic [31:0] d, logic clr = 1'b0, logic r = 1'b0);
    bd.op = op; bs.op = op;
    bd.din = d; bs.din = d;
    bd.clr_flags = clr; bs.clr_flags = clr;
    rst = r;
    @(posedge clk);
    m_apply(0, op, d, clr, r);
    m_apply(1, op, d, clr, r);
    #1;
    check_all(tag);
  endtask

  initial begin
    stack_op op;
    logic [31:0] d;
    bd.op = sNOP; bs.op = sNOP; bd.din = '0; bs.din = '0;
    bd.clr_flags = 1'b0; bs.clr_flags = 1'b0; rst = 1'b1;
`ifdef EJ32_STACK_PICK_EN
    bd.pick_idx = '0; bs.pick_idx = '0;
`endif
    for (int k = 0; k < 2; k++) begin
      etos[k] = '0; movf[k] = 1'b0; munf[k] = 1'b0;
    end

    step("reset", sPUSH, 32'h55, 1'b0, 1'b1);
    chk("reset.d.cnt", 32'(bd.cnt), 32'd0);

    step("push11", sPUSH, 32'h11);
    step("push22", sPUSH, 32'h22);
    step("push33", sPUSH, 32'h33);
    chk("p3.tos", bd.tos, 32'h33);
    chk("p3.nos", bd.nos, 32'h22);
    chk("p3.cnt", 32'(bd.cnt), 32'd3);

    step("pop1", sPOP, '0); chk("pop1.tos", bd.tos, 32'h22);
    step("pop2", sPOP, '0); chk("pop2.tos", bd.tos, 32'h11);
    step("pop3", sPOP, '0); chk("pop3.tos", bd.tos, 32'h0);
    chk("pop3.empty", 32'(bd.empty), 32'd1);
    step("pop4", sPOP, '0); chk("pop4.unf", 32'(bd.unf), 32'd1);
    step("clr", sNOP, '0, 1'b1);

    for (int i = 1; i <= 4; i++) step("fill4", sPUSH, 32'(i));
    chk("fill4.s.full", 32'(bs.full), 32'd1);
    step("push5", sPUSH, 32'd5);
    chk("push5.s.tos", bs.tos, 32'd4);
    chk("push5.s.ovf", 32'(bs.ovf), 32'd1);
    step("clr+push", sPUSH, 32'd6, 1'b1);
    chk("clrpush.s.ovf", 32'(bs.ovf), 32'd1);
    step("clr", sNOP, '0, 1'b1);

    step("rst2", sNOP, '0, 1'b0, 1'b1);
    step("mv.p1", sPUSH, 32'h11);
    step("mv.p2", sPUSH, 32'h22);
    step("move", sMOVE, 32'hDEADBEEF);
    chk("move.tos", bd.tos, 32'hDEADBEEF);
    chk("move.nos", bd.nos, 32'h11);
    chk("move.cnt", 32'(bd.cnt), 32'd2);

    for (int i = 0; i < 100; i++)
      step("alt", (i % 2 == 0) ? sPUSH : sPOP, $urandom);

    step("rst3", sNOP, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step("to5", sPUSH, $urandom);
    step("rst.mid", sPUSH, 32'h77, 1'b0, 1'b1);
    chk("rstmid.tos", bd.tos, 32'h0);
    step("rst.pop", sPOP, '0);
    chk("rstpop.unf", 32'(bd.unf), 32'd1);
    step("clr", sNOP, '0, 1'b1);

    for (int i = 0; i < DSTACK_DEPTH + 1; i++) step("bigfill", sPUSH, $urandom);
    chk("bigfill.ovf", 32'(bd.ovf), 32'd1);
    step("move.e", sMOVE, 32'hA5A5);

    for (int i = 0; i < 400; i++) begin
      op = stack_op'($urandom_range(0, 3));
      d  = $urandom;
      step("rand", op, d, $urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0);
    end

    step("rst4", sNOP, '0, 1'b0, 1'b1);
    step("move.empty", sMOVE, 32'h1234);
    chk("mvempty.unf", 32'(bd.unf), 32'd1);

`ifdef EJ32_STACK_PICK_EN
    step("rst5", sNOP, '0, 1'b1, 1'b1);
    step("pk1", sPUSH, 32'h1);
    step("pk2", sPUSH, 32'h2);
    step("pk3", sPUSH, 32'h3);
    for (int i = 0; i < 5; i++) begin
      logic [31:0] ed;
      int n = stk[0].size();
      bd.pick_idx = 6'(i);
      #1;
      ed = (i == 0) ? m_tos(0) : (i < n) ? stk[0][n-1-i] : 32'h0;
      chk("pick.data", bd.pick_data, ed);
      chk("pick.oor", 32'(bd.pick_oor), 32'(i != 0 && i >= n));
    end
    bs.pick_idx = 2'd3;
    #1;
    chk("pick.s3.data", bs.pick_data, 32'h0);
    chk("pick.s3.oor", 32'(bs.pick_oor), 32'd1);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
